// File: rtl/alu_6502_pkg.sv
// Shared types and constants for the 6502 ALU status back end.
//   flag_op_e : flag update class presented with each op
//   state_e   : sequencing state of the result/status block
//   hold_t    : ALU outputs captured for the decimal adjust cycle
//   P_*       : bit positions in the status register (NV1BDIZC)
package alu_6502_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    NZ   = 4'd1,
    NZC  = 4'd2,
    NZCV = 4'd3,
    BIT  = 4'd4,
    PLP  = 4'd5,
    CLC  = 4'd6,
    SEC  = 4'd7,
    CLI  = 4'd8,
    SEI  = 4'd9,
    CLD  = 4'd10,
    SED  = 4'd11,
    CLV  = 4'd12
  } flag_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ADJ  = 1'b1
  } state_e;

  localparam int unsigned P_C = 0;
  localparam int unsigned P_Z = 1;
  localparam int unsigned P_I = 2;
  localparam int unsigned P_D = 3;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_V = 6;
  localparam int unsigned P_N = 7;

  localparam logic [7:0] P_RESET = 8'h34;

  typedef struct packed {
    logic [7:0] out;
    logic       co;
    logic       v;
    logic       n;
    logic       z;
    logic       hc;
    logic       sub;
    logic       wr_v;   // op class includes V (NZCV)
  } hold_t;

endpackage

// File: rtl/bcd_adjust_6502.sv
// Combinational BCD nibble correction for decimal ADC/SBC.
//   din_i  : binary ALU result (BCD carries already folded in)
//   hc_i   : half carry out of the low nibble
//   co_i   : carry out of the high nibble
//   sub_i  : 1 = SBC correction, 0 = ADC correction
//   dout_o : corrected byte
// Each nibble wraps mod 16 independently; no carry between nibbles.
module bcd_adjust_6502 (
  input  logic [7:0] din_i,
  input  logic       hc_i,
  input  logic       co_i,
  input  logic       sub_i,
  output logic [7:0] dout_o
);

  logic [3:0] lo_corr;
  logic [3:0] hi_corr;

  // Subtracting 6 mod 16 is adding 10 (4'hA).
  always_comb begin
    lo_corr = '0;
    hi_corr = '0;
    if (sub_i) begin
      if (!hc_i) lo_corr = 4'hA;
      if (!co_i) hi_corr = 4'hA;
    end else begin
      if (hc_i) lo_corr = 4'h6;
      if (co_i) hi_corr = 4'h6;
    end
  end

  assign dout_o = {din_i[7:4] + hi_corr, din_i[3:0] + lo_corr};

endmodule

// File: rtl/alu_status_6502.sv
// Result and status-flag back end for the 6502 ALU.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   RDY               : global stall; low freezes every register
//   valid             : op presented; accepted when valid & RDY & ~busy
//   flag_op           : flag update class
//   adj_en, adj_sub   : ADC/SBC eligible for decimal adjust; SBC select
//   alu_out, alu_*    : registered ALU result and flags
//   din               : data byte for PLP/BIT
//   P                 : status register NV1BDIZC (bits 5,4 read 1)
//   result            : final (adjusted) result
//   res_valid         : result/P updated for an ALU op
//   busy              : decimal adjust in progress
module alu_status_6502
  import alu_6502_pkg::*;
#(
  parameter bit CMOS_FLAGS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RDY,
  input  logic       valid,
  input  flag_op_e   flag_op,
  input  logic       adj_en,
  input  logic       adj_sub,
  input  logic [7:0] alu_out,
  input  logic       alu_co,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_hc,
  input  logic [7:0] din,
  output logic [7:0] P,
  output logic [7:0] result,
  output logic       res_valid,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [7:0] p_q, p_d;
  logic [7:0] result_q, result_d;
  logic       res_valid_q, res_valid_d;
  hold_t      hold_q, hold_d;

  logic [7:0] adj;
  logic       dec_take;
  logic       dec_n;
  logic       dec_z;

  bcd_adjust_6502 u_bcd (
    .din_i  (hold_q.out),
    .hc_i   (hold_q.hc),
    .co_i   (hold_q.co),
    .sub_i  (hold_q.sub),
    .dout_o (adj)
  );

  assign dec_take = adj_en & p_q[P_D] & ((flag_op == NZC) | (flag_op == NZCV));

  assign dec_n = CMOS_FLAGS ? adj[7]         : hold_q.n;
  assign dec_z = CMOS_FLAGS ? (adj == 8'h00) : hold_q.z;

  // Next state is computed as if RDY were high; the register stage
  // applies it only when RDY is high, which makes every register hold
  // (res_valid and busy included) during a stall.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    result_d    = result_q;
    res_valid_d = 1'b0;
    hold_d      = hold_q;

    unique case (state_q)
      IDLE: begin
        if (valid) begin
          if (dec_take) begin
            hold_d.out  = alu_out;
            hold_d.co   = alu_co;
            hold_d.v    = alu_v;
            hold_d.n    = alu_n;
            hold_d.z    = alu_z;
            hold_d.hc   = alu_hc;
            hold_d.sub  = adj_sub;
            hold_d.wr_v = (flag_op == NZCV);
            state_d     = ADJ;
          end else begin
            unique case (flag_op)
              NZ, NZC, NZCV: begin
                result_d    = alu_out;
                res_valid_d = 1'b1;
                p_d[P_N]    = alu_n;
                p_d[P_Z]    = alu_z;
                if (flag_op != NZ)   p_d[P_C] = alu_co;
                if (flag_op == NZCV) p_d[P_V] = alu_v;
              end
              BIT: begin
                result_d    = alu_out;
                res_valid_d = 1'b1;
                p_d[P_N]    = din[7];
                p_d[P_V]    = din[6];
                p_d[P_Z]    = alu_z;
              end
              PLP: p_d = din | 8'h30;
              CLC: p_d[P_C] = 1'b0;
              SEC: p_d[P_C] = 1'b1;
              CLI: p_d[P_I] = 1'b0;
              SEI: p_d[P_I] = 1'b1;
              CLD: p_d[P_D] = 1'b0;
              SED: p_d[P_D] = 1'b1;
              CLV: p_d[P_V] = 1'b0;
              default: ;
            endcase
          end
        end
      end
      ADJ: begin
        result_d    = adj;
        res_valid_d = 1'b1;
        p_d[P_C]    = hold_q.co;
        if (hold_q.wr_v) p_d[P_V] = hold_q.v;
        p_d[P_N]    = dec_n;
        p_d[P_Z]    = dec_z;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      p_q         <= P_RESET;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      hold_q      <= '0;
    end else if (RDY) begin
      state_q     <= state_d;
      p_q         <= p_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      hold_q      <= hold_d;
    end
  end

  assign P         = {p_q[7:6], 2'b11, p_q[3:0]};
  assign result    = result_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q == ADJ);

endmodule

// File: tb/tb_alu_status_6502.sv
module tb_alu_status_6502;
  import alu_6502_pkg::*;

  logic       clk = 1'b0;
  logic       reset, RDY, valid;
  flag_op_e   flag_op;
  logic       adj_en, adj_sub;
  logic [7:0] alu_out, din;
  logic       alu_co, alu_v, alu_z, alu_n, alu_hc;

  logic [7:0] p0, p1, res0, res1;
  logic       rv0, rv1, busy0, busy1;

  alu_status_6502 #(.CMOS_FLAGS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .RDY(RDY), .valid(valid), .flag_op(flag_op),
    .adj_en(adj_en), .adj_sub(adj_sub), .alu_out(alu_out), .alu_co(alu_co),
    .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n), .alu_hc(alu_hc), .din(din),
    .P(p0), .result(res0), .res_valid(rv0), .busy(busy0)
  );

  alu_status_6502 #(.CMOS_FLAGS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .RDY(RDY), .valid(valid), .flag_op(flag_op),
    .adj_en(adj_en), .adj_sub(adj_sub), .alu_out(alu_out), .alu_co(alu_co),
    .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n), .alu_hc(alu_hc), .din(din),
    .P(p1), .result(res1), .res_valid(rv1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [7:0] res;
    logic [7:0] p0;
    logic [7:0] p1;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each RDY-qualified res_valid consumes one expectation.
  always @(negedge clk) begin
    if (!reset && RDY && rv0) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_rv", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result0", {24'd0, res0}, {24'd0, e.res});
        check("sb_p0",      {24'd0, p0},   {24'd0, e.p0});
        check("sb_rv1",     {31'd0, rv1},  32'd1);
        check("sb_result1", {24'd0, res1}, {24'd0, e.res});
        check("sb_p1",      {24'd0, p1},   {24'd0, e.p1});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input flag_op_e op, input logic ae, input logic sub,
                          input logic [7:0] out, input logic co, input logic v,
                          input logic z, input logic n, input logic hc,
                          input logic [7:0] d);
    valid = 1'b1; flag_op = op; adj_en = ae; adj_sub = sub;
    alu_out = out; alu_co = co; alu_v = v; alu_z = z; alu_n = n; alu_hc = hc;
    din = d;
    step();
    valid = 1'b0;
  endtask

  task automatic flag_op_only(input flag_op_e op, input logic [7:0] d);
    drive_op(op, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; RDY = 1'b1; valid = 1'b0; flag_op = NONE;
    adj_en = 1'b0; adj_sub = 1'b0; alu_out = 8'h00; din = 8'h00;
    alu_co = 1'b0; alu_v = 1'b0; alu_z = 1'b0; alu_n = 1'b0; alu_hc = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_p0",   {24'd0, p0},   32'h34);
    check("rst_p1",   {24'd0, p1},   32'h34);
    check("rst_res",  {24'd0, res0}, 32'h00);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_rv",   {31'd0, rv0},  32'd0);

    // Binary ADC with D=0: N=1 V=1 -> P=F4
    sb_q.push_back('{res: 8'h80, p0: 8'hF4, p1: 8'hF4});
    drive_op(NZCV, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check("bin_busy", {31'd0, busy0}, 32'd0);
    check("bin_rv",   {31'd0, rv0},   32'd1);
    step();
    check("bin_rv_pulse", {31'd0, rv0}, 32'd0);

    // SED: flag-only, no res_valid
    flag_op_only(SED, 8'h00);
    check("sed_p", {24'd0, p0}, 32'hFC);
    check("sed_rv", {31'd0, rv0}, 32'd0);

    // Decimal ADC 0x99+0x01 (binary AA, hc=1, co=1); a valid during ADJ is ignored
    sb_q.push_back('{res: 8'h00, p0: 8'hBD, p1: 8'h3F});
    drive_op(NZCV, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    check("dadc_busy0", {31'd0, busy0}, 32'd1);
    check("dadc_busy1", {31'd0, busy1}, 32'd1);
    check("dadc_rv_early", {31'd0, rv0}, 32'd0);
    drive_op(NZ, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("dadc_done_busy", {31'd0, busy0}, 32'd0);
    check("dadc_res", {24'd0, res0}, 32'h00);
    step();
    check("dadc_ignored_res", {24'd0, res0}, 32'h00);
    check("dadc_ignored_rv", {31'd0, rv0}, 32'd0);

    // Decimal SBC 0x10-0x01 with a 3-cycle RDY stall during ADJ
    sb_q.push_back('{res: 8'h09, p0: 8'h3D, p1: 8'h3D});
    drive_op(NZCV, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    RDY = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("stall_busy", {31'd0, busy0}, 32'd1);
      check("stall_res",  {24'd0, res0},  32'h00);
      check("stall_p0",   {24'd0, p0},    32'hBD);
    end
    RDY = 1'b1;
    step();
    check("sbc_busy", {31'd0, busy0}, 32'd0);
    check("sbc_res",  {24'd0, res0},  32'h09);
    step();

    // PLP / CLD
    flag_op_only(PLP, 8'h00);
    check("plp00_p0", {24'd0, p0}, 32'h30);
    check("plp00_p1", {24'd0, p1}, 32'h30);
    flag_op_only(PLP, 8'hFF);
    check("plpff_p", {24'd0, p0}, 32'hFF);
    flag_op_only(CLD, 8'h00);
    check("cld_p", {24'd0, p0}, 32'hF7);
    check("flag_res_hold", {24'd0, res0}, 32'h09);

    // D now clear: adj_en op takes the binary path
    sb_q.push_back('{res: 8'h1A, p0: 8'h74, p1: 8'h74});
    drive_op(NZC, 1'b1, 1'b0, 8'h1A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("d0_busy", {31'd0, busy0}, 32'd0);
    step();

    // SED then decimal op aborted by reset mid-ADJ
    flag_op_only(SED, 8'h00);
    check("sed2_p", {24'd0, p0}, 32'h7C);
    drive_op(NZCV, 1'b1, 1'b0, 8'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("abort_busy_pre", {31'd0, busy0}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_p0",   {24'd0, p0},    32'h34);
    check("abort_p1",   {24'd0, p1},    32'h34);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_res",  {24'd0, res0},  32'h00);
    check("abort_rv",   {31'd0, rv0},   32'd0);
    step();
    reset = 1'b0;
    step(); step();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
